// File: rtl/scan_seq_ctrl.sv
// scan_seq_ctrl: sequences a 2D strided address scan from a held descriptor, one address per handshake
module scan_seq_ctrl #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_x_delta,
  input  logic [CNT_W-1:0]  cfg_x_count,
  input  logic [ADDR_W-1:0] cfg_y_delta,
  input  logic [CNT_W-1:0]  cfg_y_count,
  input  logic              start,
  input  logic              abort,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_last_x,
  output logic              addr_last,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic init_q;
  logic [ADDR_W-1:0] base_q, xd_q, yd_q, row_q, addr_q;
  logic [CNT_W-1:0] xc_q, yc_q, x_idx, y_idx;
  logic cfg_hs, nz, last_x, last_y, adv;
  logic [ADDR_W-1:0] eff_base;
  assign cfg_ready = init_q & (state == IDLE);
  assign cfg_hs = cfg_valid & cfg_ready;
  // a descriptor arriving alongside start is used immediately
  assign eff_base = cfg_hs ? cfg_base : base_q;
  assign nz = cfg_hs ? (cfg_x_count != '0 && cfg_y_count != '0) : (xc_q != '0 && yc_q != '0);
  assign last_x = x_idx == xc_q - CNT_W'(1);
  assign last_y = y_idx == yc_q - CNT_W'(1);
  assign adv = (state == RUN) & addr_ready & ~abort;
  assign addr_valid = state == RUN;
  assign busy = state == RUN;
  assign done = state == DONE;
  assign addr = addr_q;
  assign addr_last_x = addr_valid & last_x;
  assign addr_last = addr_last_x & last_y;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = start ? (nz ? RUN : DONE) : IDLE;
      RUN:  state_nx = abort ? IDLE : (addr_ready & last_x & last_y) ? DONE : RUN;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q <= 1'b0;
      base_q <= '0;
      xd_q <= '0;
      yd_q <= '0;
      xc_q <= '0;
      yc_q <= '0;
      row_q <= '0;
      addr_q <= '0;
      x_idx <= '0;
      y_idx <= '0;
    end else begin
      init_q <= 1'b1;
      if (cfg_hs) begin
        base_q <= cfg_base;
        xd_q <= cfg_x_delta;
        yd_q <= cfg_y_delta;
        xc_q <= cfg_x_count;
        yc_q <= cfg_y_count;
      end
      if ((state == IDLE) & start & nz) begin
        addr_q <= eff_base;
        row_q <= eff_base;
        x_idx <= '0;
        y_idx <= '0;
      end else if (adv) begin
        if (!last_x) begin
          addr_q <= addr_q + xd_q;
          x_idx <= x_idx + CNT_W'(1);
        end else if (!last_y) begin
          row_q <= row_q + yd_q;
          addr_q <= row_q + yd_q;
          x_idx <= '0;
          y_idx <= y_idx + CNT_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_scan_seq_ctrl.sv
// tb_scan_seq_ctrl: directed checks of scan_seq_ctrl sequencing, stalls, abort, wrap and async reset
module tb_scan_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_valid = 1'b0, start = 1'b0, abort = 1'b0, addr_ready = 1'b0;
  logic [31:0] cfg_base = '0, cfg_x_delta = '0, cfg_y_delta = '0;
  logic [11:0] cfg_x_count = '0, cfg_y_count = '0;
  logic cfg_ready, addr_valid, addr_last_x, addr_last, busy, done;
  logic [31:0] addr;
  int n_cmp = 0, n_err = 0;

  scan_seq_ctrl #(.ADDR_W(32), .CNT_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_base(cfg_base), .cfg_x_delta(cfg_x_delta), .cfg_x_count(cfg_x_count),
    .cfg_y_delta(cfg_y_delta), .cfg_y_count(cfg_y_count), .start(start), .abort(abort),
    .addr_valid(addr_valid), .addr_ready(addr_ready), .addr(addr),
    .addr_last_x(addr_last_x), .addr_last(addr_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load(input logic [31:0] b, xd, input int xc, input logic [31:0] yd, input int yc, input bit st);
    cfg_base = b; cfg_x_delta = xd; cfg_x_count = 12'(xc);
    cfg_y_delta = yd; cfg_y_count = 12'(yc);
    cfg_valid = 1'b1; start = st;
    chk("cfg_ready_idle", {31'b0, cfg_ready}, 32'd1);
    step();
    cfg_valid = 1'b0; start = 1'b0;
  endtask

  // Called at the negedge after the start edge; walks the scan against an index model
  task automatic scan(input string tag, input logic [31:0] b, xd, input int xc, input logic [31:0] yd, input int yc, input bit tog);
    int x = 0, y = 0, n = 0, cyc = 0;
    bit seen = 0;
    logic [31:0] exp_a;
    while (!seen && cyc < 200) begin
      addr_ready = tog ? ((cyc % 3) == 0) : 1'b1;
      if (done) begin
        seen = 1;
        chk({tag, "_done_valid"}, {31'b0, addr_valid}, 32'd0);
        chk({tag, "_done_busy"}, {31'b0, busy}, 32'd0);
      end else if (addr_valid) begin
        exp_a = b + 32'(y) * yd + 32'(x) * xd;
        chk({tag, "_addr"}, addr, exp_a);
        chk({tag, "_last_x"}, {31'b0, addr_last_x}, {31'b0, x == xc - 1});
        chk({tag, "_last"}, {31'b0, addr_last}, {31'b0, (x == xc - 1) && (y == yc - 1)});
        if (addr_ready) begin
          n++;
          if (x == xc - 1) begin x = 0; y++; end else x++;
        end
      end
      if (!seen) step();
      cyc++;
    end
    chk({tag, "_done_seen"}, {31'b0, seen}, 32'd1);
    chk({tag, "_count"}, 32'(n), 32'(xc * yc));
    step();
    chk({tag, "_done_one_cycle"}, {31'b0, done}, 32'd0);
    chk({tag, "_back_idle"}, {31'b0, cfg_ready}, 32'd1);
    addr_ready = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_cfg_ready", {31'b0, cfg_ready}, 32'd0);
    chk("rst_valid", {31'b0, addr_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_addr", addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("cfg_ready_before_edge", {31'b0, cfg_ready}, 32'd0);
    step();
    chk("cfg_ready_after_edge", {31'b0, cfg_ready}, 32'd1);

    addr_ready = 1'b1;
    load(32'h100, 32'd4, 3, 32'h40, 2, 1'b1);
    chk("t1_first_addr", addr, 32'h100);
    chk("t1_busy", {31'b0, busy}, 32'd1);
    scan("t1", 32'h100, 32'd4, 3, 32'h40, 2, 1'b0);

    start = 1'b1;
    step();
    start = 1'b0;
    scan("t2_stall", 32'h100, 32'd4, 3, 32'h40, 2, 1'b1);

    load(32'h200, 32'd4, 0, 32'h40, 2, 1'b1);
    chk("zero_done", {31'b0, done}, 32'd1);
    chk("zero_valid", {31'b0, addr_valid}, 32'd0);
    chk("zero_busy", {31'b0, busy}, 32'd0);
    step();
    chk("zero_done_drop", {31'b0, done}, 32'd0);
    chk("zero_valid_after", {31'b0, addr_valid}, 32'd0);

    addr_ready = 1'b1;
    load(32'h100, 32'd4, 3, 32'h40, 2, 1'b1);
    chk("ab_a0", addr, 32'h100);
    step();
    chk("ab_a1", addr, 32'h104);
    step();
    chk("ab_a2", addr, 32'h108);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_valid", {31'b0, addr_valid}, 32'd0);
    chk("ab_done", {31'b0, done}, 32'd0);
    chk("ab_busy", {31'b0, busy}, 32'd0);
    chk("ab_idle", {31'b0, cfg_ready}, 32'd1);
    step();
    chk("ab_no_done_later", {31'b0, done}, 32'd0);
    chk("ab_no_valid_later", {31'b0, addr_valid}, 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    scan("ab_restart", 32'h100, 32'd4, 3, 32'h40, 2, 1'b0);

    load(32'hFFFF_FFFC, 32'd8, 2, 32'd0, 1, 1'b1);
    chk("wrap_a0", addr, 32'hFFFF_FFFC);
    scan("wrap", 32'hFFFF_FFFC, 32'd8, 2, 32'd0, 1, 1'b0);

    addr_ready = 1'b1;
    load(32'h100, 32'd4, 3, 32'h40, 2, 1'b1);
    step();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'b0, addr_valid}, 32'd0);
    chk("ar_busy", {31'b0, busy}, 32'd0);
    chk("ar_done", {31'b0, done}, 32'd0);
    chk("ar_cfg_ready", {31'b0, cfg_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("ar_cfg_ready_after", {31'b0, cfg_ready}, 32'd1);
    chk("ar_no_done", {31'b0, done}, 32'd0);
    load(32'h1000, 32'd16, 2, 32'h100, 2, 1'b1);
    chk("ar_new_a0", addr, 32'h1000);
    scan("ar_new", 32'h1000, 32'd16, 2, 32'h100, 2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
